// File: rtl/slc_config_loader.sv
// rtl/slc_config_loader.sv - byte-serial configuration loader with shadow/active commit for the 8-cell super logic cell
module slc_config_loader #(
  parameter int          NUM_LC  = 8,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int          TIMEOUT = 64
) (
  input  logic                   QCK,
  input  logic                   QRT,
  input  logic [7:0]             IN_DATA,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [NUM_LC*16-1:0]   LUT_INIT,
  output logic [NUM_LC*2-1:0]    MODE,
  output logic [NUM_LC-1:0]      QDI_SEL,
  output logic [NUM_LC-1:0]      BQZ_SEL,
  output logic [NUM_LC-1:0]      CQZ_SEL,
  output logic                   BUSY,
  output logic                   CFG_DONE,
  output logic                   ERR,
  output logic [1:0]             ERR_CODE
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_COMMIT, S_ABORT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      frame;
  logic [1:0]      phase;
  logic [7:0]      xsum;
  logic            mismatch;
  logic [TW-1:0]   idle_cnt;
  logic [1:0]      pend_code, code_nxt;

  logic [15:0]       sh_lut  [NUM_LC];
  logic [1:0]        sh_mode [NUM_LC];
  logic [NUM_LC-1:0] sh_qdi, sh_bqz, sh_cqz;

  logic accept, timed_out, last_byte;

  assign IN_READY  = (state == S_IDLE) || (state == S_LOAD) || (state == S_CHECK);
  assign BUSY      = (state != S_IDLE);
  assign accept    = IN_VALID & IN_READY;
  // A byte arriving on the cycle the counter would expire takes precedence.
  assign timed_out = !accept && (idle_cnt == TW'(TIMEOUT - 1));
  assign last_byte = (phase == 2'd2) && (frame == 3'(NUM_LC - 1));

  always_comb begin
    state_nxt = state;
    code_nxt  = pend_code;
    case (state)
      S_IDLE: begin
        if (accept && IN_DATA == HEADER) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (accept && last_byte) begin
          state_nxt = S_CHECK;
        end else if (timed_out) begin
          state_nxt = S_ABORT;
          code_nxt  = 2'd3;
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (mismatch) begin
            state_nxt = S_ABORT;
            code_nxt  = 2'd2;
          end else if (IN_DATA != xsum) begin
            state_nxt = S_ABORT;
            code_nxt  = 2'd1;
          end else begin
            state_nxt = S_COMMIT;
          end
        end else if (timed_out) begin
          state_nxt = S_ABORT;
          code_nxt  = 2'd3;
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      S_ABORT:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge QCK) begin
    if (QRT) begin
      state     <= S_IDLE;
      frame     <= '0;
      phase     <= '0;
      xsum      <= '0;
      mismatch  <= 1'b0;
      idle_cnt  <= '0;
      pend_code <= '0;
      for (int k = 0; k < NUM_LC; k++) begin
        sh_lut[k]  <= '0;
        sh_mode[k] <= '0;
      end
      sh_qdi    <= '0;
      sh_bqz    <= '0;
      sh_cqz    <= '0;
      LUT_INIT  <= '0;
      MODE      <= '0;
      QDI_SEL   <= '0;
      BQZ_SEL   <= '0;
      CQZ_SEL   <= '0;
      CFG_DONE  <= 1'b0;
      ERR       <= 1'b0;
      ERR_CODE  <= '0;
    end else begin
      state     <= state_nxt;
      pend_code <= code_nxt;
      CFG_DONE  <= (state == S_COMMIT);
      ERR       <= (state == S_ABORT);

      if (state == S_ABORT) ERR_CODE <= pend_code;

      if (state == S_COMMIT) begin
        for (int k = 0; k < NUM_LC; k++) begin
          LUT_INIT[16*k +: 16] <= sh_lut[k];
          MODE[2*k +: 2]       <= sh_mode[k];
        end
        QDI_SEL <= sh_qdi;
        BQZ_SEL <= sh_bqz;
        CQZ_SEL <= sh_cqz;
      end

      if (state == S_LOAD || state == S_CHECK)
        idle_cnt <= accept ? '0 : idle_cnt + 1'b1;
      else
        idle_cnt <= '0;

      if (state == S_IDLE && accept && IN_DATA == HEADER) begin
        frame    <= '0;
        phase    <= '0;
        xsum     <= '0;
        mismatch <= 1'b0;
      end

      if (state == S_LOAD && accept) begin
        xsum <= xsum ^ IN_DATA;
        case (phase)
          2'd0: sh_lut[frame][7:0]  <= IN_DATA;
          2'd1: sh_lut[frame][15:8] <= IN_DATA;
          default: begin
            sh_mode[frame] <= IN_DATA[1:0];
            sh_qdi[frame]  <= IN_DATA[2];
            sh_bqz[frame]  <= IN_DATA[3];
            sh_cqz[frame]  <= IN_DATA[4];
            if (IN_DATA[7:5] != frame) mismatch <= 1'b1;
          end
        endcase
        if (phase == 2'd2) begin
          phase <= 2'd0;
          frame <= frame + 3'd1;
        end else begin
          phase <= phase + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_slc_config_loader.sv
// tb/tb_slc_config_loader.sv - randomized self-checking bench for slc_config_loader
module tb_slc_config_loader;

  logic         QCK = 1'b0;
  logic         QRT = 1'b1;
  logic [7:0]   IN_DATA = 8'h00;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [127:0] LUT_INIT;
  logic [15:0]  MODE;
  logic [7:0]   QDI_SEL, BQZ_SEL, CQZ_SEL;
  logic         BUSY, CFG_DONE, ERR;
  logic [1:0]   ERR_CODE;

  int tests = 0;
  int fails = 0;

  // Frames of the load being sent, and the model's view of the active configuration.
  logic [15:0] f_lut [8];
  logic [1:0]  f_mode[8];
  logic        f_q[8], f_b[8], f_c[8];
  logic [2:0]  f_idx[8];
  logic [15:0] m_lut [8];
  logic [1:0]  m_mode[8];
  logic        m_q[8], m_b[8], m_c[8];
  logic [1:0]  m_code;

  slc_config_loader dut (
    .QCK(QCK), .QRT(QRT), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .LUT_INIT(LUT_INIT), .MODE(MODE), .QDI_SEL(QDI_SEL), .BQZ_SEL(BQZ_SEL), .CQZ_SEL(CQZ_SEL),
    .BUSY(BUSY), .CFG_DONE(CFG_DONE), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 QCK = ~QCK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge QCK);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) begin
      m_lut[k] = '0; m_mode[k] = '0; m_q[k] = 0; m_b[k] = 0; m_c[k] = 0;
    end
    m_code = 2'd0;
  endtask

  task automatic set_zero_frames();
    for (int k = 0; k < 8; k++) begin
      f_lut[k] = '0; f_mode[k] = '0; f_q[k] = 0; f_b[k] = 0; f_c[k] = 0; f_idx[k] = 3'(k);
    end
  endtask

  task automatic set_random_frames();
    for (int k = 0; k < 8; k++) begin
      f_lut[k]  = 16'($urandom);
      f_mode[k] = 2'($urandom);
      f_q[k]    = 1'($urandom);
      f_b[k]    = 1'($urandom);
      f_c[k]    = 1'($urandom);
      f_idx[k]  = 3'(k);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [127:0] el;
    logic [15:0]  em;
    logic [7:0]   eq, eb, ec;
    for (int k = 0; k < 8; k++) begin
      el[16*k +: 16] = m_lut[k];
      em[2*k +: 2]   = m_mode[k];
      eq[k] = m_q[k]; eb[k] = m_b[k]; ec[k] = m_c[k];
    end
    chk({tag, "_lut_init"}, LUT_INIT, el);
    chk({tag, "_mode"}, MODE, em);
    chk({tag, "_qdi_sel"}, QDI_SEL, eq);
    chk({tag, "_bqz_sel"}, BQZ_SEL, eb);
    chk({tag, "_cqz_sel"}, CQZ_SEL, ec);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    IN_DATA  = b;
    IN_VALID = 1'b1;
    n = 0;
    while (!IN_READY && n < 20) begin
      step();
      n++;
    end
    if (!IN_READY) chk("in_ready_wait", IN_READY, 1);
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic stream_bytes(input int n, input int gap_after, input int gap_len, output logic [7:0] x);
    logic [7:0] b;
    x = 8'h00;
    for (int j = 0; j < n; j++) begin
      if (j % 3 == 0)      b = f_lut[j/3][7:0];
      else if (j % 3 == 1) b = f_lut[j/3][15:8];
      else                 b = {f_idx[j/3], f_c[j/3], f_b[j/3], f_q[j/3], f_mode[j/3]};
      x ^= b;
      send_byte(b);
      if (j + 1 == gap_after) repeat (gap_len) step();
    end
  endtask

  task automatic finish_load(input logic [7:0] mask, input logic [7:0] x);
    logic bad_idx;
    logic [1:0] ecode;
    send_byte(x ^ mask);
    chk("busy_after_chk", BUSY, 1);
    chk("ready_after_chk", IN_READY, 0);
    chk("done_early", CFG_DONE, 0);
    bad_idx = 0;
    for (int k = 0; k < 8; k++) if (f_idx[k] != 3'(k)) bad_idx = 1;
    ecode = bad_idx ? 2'd2 : (mask != 0) ? 2'd1 : 2'd0;
    step();
    if (ecode == 2'd0) begin
      for (int k = 0; k < 8; k++) begin
        m_lut[k] = f_lut[k]; m_mode[k] = f_mode[k];
        m_q[k] = f_q[k]; m_b[k] = f_b[k]; m_c[k] = f_c[k];
      end
      chk("cfg_done_pulse", CFG_DONE, 1);
      chk("err_on_commit", ERR, 0);
    end else begin
      m_code = ecode;
      chk("err_pulse", ERR, 1);
      chk("done_on_abort", CFG_DONE, 0);
    end
    chk("err_code", ERR_CODE, m_code);
    chk("busy_end", BUSY, 0);
    chk("ready_end", IN_READY, 1);
    check_outputs("load");
    step();
    chk("done_clear", CFG_DONE, 0);
    chk("err_clear", ERR, 0);
  endtask

  task automatic full_load(input logic [7:0] mask, input int gap_after, input int gap_len);
    logic [7:0] x;
    send_byte(8'hA5);
    stream_bytes(24, gap_after, gap_len, x);
    finish_load(mask, x);
  endtask

  initial begin
    logic [7:0] x;
    int sel, kk, ng;
    logic [7:0] g, mask;

    clear_model();
    repeat (3) @(posedge QCK);
    #1;
    QRT = 1'b0;
    check_outputs("reset");
    chk("reset_busy", BUSY, 0);
    chk("reset_ready", IN_READY, 1);
    chk("reset_done", CFG_DONE, 0);
    chk("reset_err", ERR, 0);
    chk("reset_err_code", ERR_CODE, 0);

    set_zero_frames();
    full_load(8'h00, 0, 0);

    set_zero_frames();
    f_lut[3] = 16'h1234; f_mode[3] = 2'd3; f_q[3] = 1; f_b[3] = 1; f_c[3] = 1;
    full_load(8'h00, 0, 0);
    chk("cell3_lut", LUT_INIT[63:48], 16'h1234);
    chk("cell3_mode", MODE[7:6], 2'b11);
    chk("cell3_sels", {QDI_SEL[3], BQZ_SEL[3], CQZ_SEL[3]}, 3'b111);

    full_load(8'h01, 0, 0);

    f_idx[5] = 3'd4;
    full_load(8'h01, 0, 0);
    f_idx[5] = 3'd5;

    set_random_frames();
    send_byte(8'hA5);
    stream_bytes(10, 0, 0, x);
    repeat (64) step();
    chk("timeout_in_abort_busy", BUSY, 1);
    chk("timeout_in_abort_ready", IN_READY, 0);
    chk("timeout_no_early_err", ERR, 0);
    step();
    m_code = 2'd3;
    chk("timeout_err", ERR, 1);
    chk("timeout_err_code", ERR_CODE, m_code);
    chk("timeout_busy", BUSY, 0);
    check_outputs("timeout");
    step();
    chk("timeout_err_clear", ERR, 0);

    set_random_frames();
    full_load(8'h00, 10, 63);

    set_random_frames();
    full_load(8'h00, 0, 0);
    set_random_frames();
    send_byte(8'hA5);
    stream_bytes(15, 0, 0, x);
    QRT = 1'b1;
    step();
    QRT = 1'b0;
    clear_model();
    check_outputs("midreset");
    chk("midreset_ready", IN_READY, 1);
    chk("midreset_busy", BUSY, 0);
    chk("midreset_err", ERR, 0);
    chk("midreset_err_code", ERR_CODE, 0);
    repeat (3) begin
      step();
      chk("midreset_no_err", ERR, 0);
    end

    send_byte(8'h00);
    send_byte(8'hFF);
    set_random_frames();
    full_load(8'h00, 0, 0);

    for (int it = 0; it < 12; it++) begin
      set_random_frames();
      ng = $urandom_range(0, 2);
      for (int i = 0; i < ng; i++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
      end
      sel = $urandom_range(0, 3);
      mask = 8'h00;
      if (sel == 2) mask = 8'($urandom_range(1, 255));
      if (sel == 3) begin
        kk = $urandom_range(0, 7);
        f_idx[kk] = 3'(kk) ^ 3'($urandom_range(1, 7));
        mask = 8'($urandom);
      end
      full_load(mask, $urandom_range(1, 24), $urandom_range(0, 63));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
